// File: rtl/svga_timing_pkg.sv
// Shared constants for the SVGA raster timing generator: counter widths,
// the vertical-repeat encoding and the timing-total helper.
package svga_timing_pkg;

  // Raster position counters (sized for totals up to 2047).
  localparam int HCNT_W    = 11;
  localparam int VCNT_W    = 11;
  // Pixel divider, CLK_DIV up to 8.
  localparam int DIV_W     = 3;
  // Address counter widths, matching the fetch pipeline ports.
  localparam int SUBPIX_W  = 5;
  localparam int COL_W     = 7;
  localparam int SUBLINE_W = 5;
  localparam int ROW_W     = 7;
  localparam int GPIX_W    = 10;
  localparam int GLINE_W   = 9;
  localparam int PHASE_W   = 2;

  // Vertical repeat factor for graph_line.
  typedef enum logic [1:0] {
    YREP_1X = 2'd0,
    YREP_2X = 2'd1,
    YREP_3X = 2'd2,
    YREP_4X = 2'd3
  } yrep_e;

  // Total pixels per line or lines per frame.
  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/svga_wrap_counter.sv
// Enabled up-counter that returns to zero after reaching wrap_val.
// carry flags the enabled step that wraps, so counters can be chained.
module svga_wrap_counter #(
  parameter int W = 8
) (
  input  logic         pixel_clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] wrap_val,
  output logic [W-1:0] count,
  output logic         carry
);

  logic [W-1:0] count_nxt;

  // Next count: clear wins, then wrap, then increment.
  always_comb begin
    carry = en && (count == wrap_val);
    if (clr)
      count_nxt = '0;
    else if (carry)
      count_nxt = '0;
    else if (en)
      count_nxt = count + 1'b1;
    else
      count_nxt = count;
  end

  // Count register.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset)
      count <= '0;
    else
      count <= count_nxt;
  end

endmodule

// File: rtl/svga_timing_gen_param.sv
// Single-clock SVGA raster timing generator. All state runs on pixel_clock,
// advancing on an internal pixel enable; produces sync/blank/border and the
// text-cell and graphics addresses for the VRAM/font/palette fetch.
module svga_timing_gen_param
  import svga_timing_pkg::*;
#(
  parameter int   H_ACTIVE     = 640,
  parameter int   H_FP         = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BP         = 48,
  parameter int   V_ACTIVE     = 480,
  parameter int   V_FP         = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BP         = 33,
  parameter logic HS_POL       = 1'b0,
  parameter logic VS_POL       = 1'b0,
  parameter int   CLK_DIV      = 1,
  parameter int   WIN_X        = 64,
  parameter int   WIN_Y        = 48,
  parameter int   WIN_W        = 512,
  parameter int   WIN_H        = 384,
  parameter int   CHAR_W       = 8,
  parameter int   CHAR_H       = 12,
  parameter int   XREP         = 2,
  parameter int   DECODE_DELAY = 1
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic [1:0] yrep,
  output logic       pix_ce,
  output logic       h_synch,
  output logic       v_synch,
  output logic       blank,
  output logic       show_border,
  output logic       line_start,
  output logic       frame_start,
  output logic [4:0] subchar_pixel,
  output logic [6:0] char_column,
  output logic [4:0] subchar_line,
  output logic [6:0] char_line,
  output logic [9:0] graph_pixel,
  output logic [8:0] graph_line
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HCNT_W-1:0]    H_LAST    = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0]    H_ACT_END = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0]    HS_START  = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0]    HS_END    = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCNT_W-1:0]    WX0       = HCNT_W'(WIN_X);
  localparam logic [HCNT_W-1:0]    WX1       = HCNT_W'(WIN_X + WIN_W);
  localparam logic [HCNT_W-1:0]    RUN0      = HCNT_W'(WIN_X - DECODE_DELAY);
  localparam logic [HCNT_W-1:0]    RUN1      = HCNT_W'(WIN_X + WIN_W - DECODE_DELAY);
  localparam logic [VCNT_W-1:0]    V_LAST    = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0]    V_ACT_END = VCNT_W'(V_ACTIVE);
  localparam logic [VCNT_W-1:0]    VS_START  = VCNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCNT_W-1:0]    VS_END    = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCNT_W-1:0]    WY0       = VCNT_W'(WIN_Y);
  localparam logic [VCNT_W-1:0]    WY1       = VCNT_W'(WIN_Y + WIN_H);
  localparam logic [SUBPIX_W-1:0]  SP_LAST   = SUBPIX_W'(CHAR_W * XREP - 1);
  localparam logic [SUBLINE_W-1:0] SL_LAST   = SUBLINE_W'(CHAR_H * 2 - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_nxt;
  logic               tick;
  logic [HCNT_W-1:0]  h_cnt;
  logic [HCNT_W-1:0]  h_nxt;
  logic [VCNT_W-1:0]  v_cnt;
  logic [VCNT_W-1:0]  v_nxt;
  logic               h_carry;
  logic               v_carry;
  logic               win_v;
  logic               in_run;
  logic               v_adv;
  logic               act_nxt;
  logic               win_nxt;
  logic               hs_nxt;
  logic               vs_nxt;
  logic               sp_carry;
  logic               sl_carry;
  logic               ph_carry;
  logic [PHASE_W-1:0] phase;
  logic [1:0]         yrep_q;
  logic [3:0]         unused_carry;

  // Pixel divider; tick marks the clock edge that starts a pixel-enable cycle.
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    tick    = (div_nxt == DIV_LAST);
  end

  // Divider state and registered pixel enable, aligned with the counter updates.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pix_ce  <= tick;
    end
  end

  // Raster position.
  svga_wrap_counter #(.W(HCNT_W)) u_h_cnt (
    .pixel_clock(pixel_clock), .reset(reset), .en(tick), .clr(1'b0),
    .wrap_val(H_LAST), .count(h_cnt), .carry(h_carry)
  );

  svga_wrap_counter #(.W(VCNT_W)) u_v_cnt (
    .pixel_clock(pixel_clock), .reset(reset), .en(h_carry), .clr(1'b0),
    .wrap_val(V_LAST), .count(v_cnt), .carry(v_carry)
  );

  // Window/run qualifiers on the current position; decodes on the position after this tick.
  always_comb begin
    h_nxt   = h_carry ? '0 : h_cnt + 1'b1;
    v_nxt   = v_carry ? '0 : (h_carry ? v_cnt + 1'b1 : v_cnt);
    win_v   = (v_cnt >= WY0) && (v_cnt < WY1);
    in_run  = win_v && (h_cnt >= RUN0) && (h_cnt < RUN1);
    v_adv   = h_carry && win_v;
    act_nxt = (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
    win_nxt = (h_nxt >= WX0) && (h_nxt < WX1) && (v_nxt >= WY0) && (v_nxt < WY1);
    hs_nxt  = (h_nxt >= HS_START) && (h_nxt < HS_END);
    vs_nxt  = (v_nxt >= VS_START) && (v_nxt < VS_END);
  end

  // Registered timing decodes; the pulses coincide with the counters reaching zero.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      h_synch     <= ~HS_POL;
      v_synch     <= ~VS_POL;
      blank       <= 1'b1;
      show_border <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick) begin
      h_synch     <= hs_nxt ? HS_POL : ~HS_POL;
      v_synch     <= vs_nxt ? VS_POL : ~VS_POL;
      blank       <= ~act_nxt;
      show_border <= act_nxt && !win_nxt;
      line_start  <= h_carry;
      frame_start <= v_carry;
    end
  end

  // Horizontal addresses: step through the run, cleared as each line begins.
  svga_wrap_counter #(.W(SUBPIX_W)) u_subchar_pixel (
    .pixel_clock(pixel_clock), .reset(reset), .en(tick && in_run), .clr(h_carry),
    .wrap_val(SP_LAST), .count(subchar_pixel), .carry(sp_carry)
  );

  svga_wrap_counter #(.W(COL_W)) u_char_column (
    .pixel_clock(pixel_clock), .reset(reset), .en(sp_carry), .clr(h_carry),
    .wrap_val('1), .count(char_column), .carry(unused_carry[0])
  );

  svga_wrap_counter #(.W(GPIX_W)) u_graph_pixel (
    .pixel_clock(pixel_clock), .reset(reset), .en(tick && in_run), .clr(h_carry),
    .wrap_val('1), .count(graph_pixel), .carry(unused_carry[1])
  );

  // Vertical repeat factor, picked up only at frame start.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset)
      yrep_q <= YREP_1X;
    else if (v_carry)
      yrep_q <= yrep;
  end

  // Vertical addresses: advance when leaving a window line, cleared at frame start.
  svga_wrap_counter #(.W(SUBLINE_W)) u_subchar_line (
    .pixel_clock(pixel_clock), .reset(reset), .en(v_adv), .clr(v_carry),
    .wrap_val(SL_LAST), .count(subchar_line), .carry(sl_carry)
  );

  svga_wrap_counter #(.W(ROW_W)) u_char_line (
    .pixel_clock(pixel_clock), .reset(reset), .en(sl_carry), .clr(v_carry),
    .wrap_val('1), .count(char_line), .carry(unused_carry[2])
  );

  svga_wrap_counter #(.W(PHASE_W)) u_y_phase (
    .pixel_clock(pixel_clock), .reset(reset), .en(v_adv), .clr(v_carry),
    .wrap_val(yrep_q), .count(phase), .carry(ph_carry)
  );

  svga_wrap_counter #(.W(GLINE_W)) u_graph_line (
    .pixel_clock(pixel_clock), .reset(reset), .en(ph_carry), .clr(v_carry),
    .wrap_val('1), .count(graph_line), .carry(unused_carry[3])
  );

endmodule
